// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = a - b, computed LSB first as a + ~b + 1
// using one full-adder slice per cycle. Start/busy/done handshake; results held until the next done.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-2:0] sreg;
  logic [CW-1:0]    cnt;
  logic             carry;

  logic             accept;
  logic             last;
  logic             b_inv;
  logic             sum;
  logic             cout;
  logic [WIDTH-1:0] word;

  assign accept = start && (state != S_RUN);
  assign last   = (cnt == CW'(WIDTH - 1));

  // Full-adder slice on the current LSBs; the subtrahend bit is inverted for a + ~b + 1
  assign b_inv = ~b_sh[0];
  assign sum   = a_sh[0] ^ b_inv ^ carry;
  assign cout  = (a_sh[0] & b_inv) | (a_sh[0] & carry) | (b_inv & carry);
  assign word  = {sum, sreg};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (last) state_nxt = S_DONE;
      S_DONE:  state_nxt = start ? S_RUN : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == S_RUN);
    done = (state == S_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_sh     <= '0;
      b_sh     <= '0;
      sreg     <= '0;
      cnt      <= '0;
      carry    <= 1'b0;
      diff     <= '0;
      borrow   <= 1'b0;
      overflow <= 1'b0;
    end else if (accept) begin
      a_sh  <= a;
      b_sh  <= b;
      sreg  <= '0;
      cnt   <= '0;
      carry <= 1'b1;
    end else if (state == S_RUN) begin
      a_sh  <= a_sh >> 1;
      b_sh  <= b_sh >> 1;
      sreg  <= word[WIDTH-1:1];
      cnt   <= cnt + CW'(1);
      carry <= cout;
      // On the MSB, carry holds the carry into the MSB and cout the final carry
      if (last) begin
        diff     <= word;
        borrow   <= ~cout;
        overflow <= carry ^ cout;
      end
    end
  end

endmodule
